// File: rtl/mantissa_normalize_pkg.sv
// Shared floating-point constants and FSM encodings for the adder datapath.
package mantissa_normalize_pkg;

    localparam int EXP_W   = 4;
    localparam int MAN_W   = 7;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } norm_state_e;

    // Largest exponent code for a given field width.
    function automatic int exp_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mantissa_normalize_if.sv
// Operand/result handshake bundle for the normalizer. The master drives
// operands and accepts results; the slave is the normalizer itself.
interface mantissa_normalize_if #(
    parameter int EXP_W = mantissa_normalize_pkg::EXP_W,
    parameter int MAN_W = mantissa_normalize_pkg::MAN_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MAN_W+1:0]         sum_m;
    logic [EXP_W-1:0]         exp_in;
    logic                     sign_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+MAN_W:0]     result;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output in_valid, sum_m, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, sum_m, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/mantissa_normalize_norm_step.sv
// One normalization step: decides whether the mantissa is finished and,
// if not, computes the shifted mantissa and adjusted exponent.
module norm_step #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7
) (
    input  logic [MAN_W+1:0] m_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [MAN_W+1:0] m_d,
    output logic [EXP_W-1:0] exp_d,
    output logic             done_o,
    output logic             ovf_o,
    output logic             unf_o
);
    import mantissa_normalize_pkg::*;

    localparam logic [EXP_W-1:0] EXP_LIM = EXP_W'(exp_max(EXP_W));
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    // Priority: zero, carry (right shift or saturate), already normal,
    // exponent exhausted (flush), otherwise one left shift.
    always_comb begin
        m_d    = m_i;
        exp_d  = exp_i;
        done_o = 1'b0;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        if (m_i == '0) begin
            exp_d  = '0;
            done_o = 1'b1;
        end else if (m_i[MAN_W+1]) begin
            done_o = 1'b1;
            if (exp_i == EXP_LIM) begin
                m_d   = '0;
                ovf_o = 1'b1;
            end else begin
                m_d   = m_i >> 1;
                exp_d = exp_i + EXP_ONE;
            end
        end else if (m_i[MAN_W]) begin
            done_o = 1'b1;
        end else if (exp_i <= EXP_ONE) begin
            m_d    = '0;
            exp_d  = '0;
            unf_o  = 1'b1;
            done_o = 1'b1;
        end else begin
            m_d   = m_i << 1;
            exp_d = exp_i - EXP_ONE;
        end
    end
endmodule

// File: rtl/mantissa_normalize.sv
// Post-add mantissa normalizer: accepts a raw adder mantissa and exponent,
// shifts one position per cycle until normal, then holds the packed result
// until the consumer takes it.
module mantissa_normalize #(
    parameter int EXP_W = mantissa_normalize_pkg::EXP_W,
    parameter int MAN_W = mantissa_normalize_pkg::MAN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mantissa_normalize_if.slave  bus
);
    import mantissa_normalize_pkg::*;

    norm_state_e        state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [MAN_W+1:0]   m_q;
    logic [EXP_W-1:0]   exp_q;
    logic               sign_q;
    logic               ovf_q;
    logic               unf_q;

    logic [MAN_W+1:0]   m_d;
    logic [EXP_W-1:0]   exp_d;
    logic               step_done;
    logic               step_ovf;
    logic               step_unf;

    norm_step #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_step (
        .m_i    (m_q),
        .exp_i  (exp_q),
        .m_d    (m_d),
        .exp_d  (exp_d),
        .done_o (step_done),
        .ovf_o  (step_ovf),
        .unf_o  (step_unf)
    );

    // Control FSM with registered handshake outputs and working registers.
    // The result is read straight from the working registers, so it is
    // frozen for as long as the FSM sits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        m_q        <= bus.sum_m;
                        exp_q      <= bus.exp_in;
                        sign_q     <= bus.sign_in;
                        ovf_q      <= 1'b0;
                        unf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    m_q   <= m_d;
                    exp_q <= exp_d;
                    ovf_q <= step_ovf;
                    unf_q <= step_unf;
                    if (step_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = {sign_q, exp_q, m_q[MAN_W-1:0]};
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule
